cam_stream_gen: RTL and testbench

Synthesizable OV7670-style camera stream generator. It drives `CAM_pclk`, `CAM_vsync`, `CAM_href` and 8-bit RGB444 pixel bytes into the capture path (`test_cam` camera inputs). It replaces the hand-coded stimulus `initial` loops with a parametrised block usable in simulation and on the FPGA for self-test. Frame geometry, blanking, pixel-clock ratio and test pattern are all configurable.

---
 rtl/cam_gen_pkg.sv | 27 ++
 rtl/cam_gen_pattern.sv | 49 ++++
 rtl/cam_stream_gen.sv | 205 ++++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_gen_pkg.sv
// ============================================================================
//  Module      : cam_gen_pkg
//  Description : Shared encodings and the RGB444 byte-packing helper for the
//                camera stream generator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cam_gen_pkg;

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_VBAR  = 2'd1;
    localparam logic [1:0] MODE_HBAR  = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Even byte carries {0,R}, odd byte carries {G,B}.
    function automatic logic [7:0] rgb444_byte(input logic [11:0] color, input logic odd);
        return odd ? color[7:0] : {4'h0, color[11:8]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_gen_pattern.sv
// ============================================================================
//  Module      : cam_gen_pattern
//  Description : Combinational test-pattern colour select from pixel x/y,
//                the frame-latched mode and the two frame-latched colours.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_gen_pattern
    import cam_gen_pkg::*;
#(
    parameter int XW    = 8,
    parameter int YW    = 8,
    parameter int BAR_W = 2
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [1:0]    mode_i,
    input  logic [11:0]   color_a_i,
    input  logic [11:0]   color_b_i,
    output logic [11:0]   color_o
);

    localparam int c_sh = $clog2(BAR_W);

    // BAR_W is a power of two, so dividing by it is a plain shift.
    logic [XW-1:0] w_xs;
    logic [YW-1:0] w_ys;
    logic          w_sel;

    assign w_xs = x_i >> c_sh;
    assign w_ys = y_i >> c_sh;

    always_comb begin
        w_sel = 1'b0;
        case (mode_i)
            MODE_SOLID: w_sel = 1'b0;
            MODE_VBAR:  w_sel = w_xs[0];
            MODE_HBAR:  w_sel = w_ys[0];
            MODE_CHECK: w_sel = w_xs[0] ^ w_ys[0];
            default:    w_sel = 1'b0;
        endcase
    end

    assign color_o = w_sel ? color_b_i : color_a_i;

endmodule

`default_nettype wire

// File: rtl/cam_stream_gen.sv
// ============================================================================
//  Module      : cam_stream_gen
//  Description : OV7670-style camera stream generator (pclk/vsync/href/RGB444
//                bytes). Define CAM_GEN_FRAME_CNT_EN to enable frame_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cam_stream_gen
    import cam_gen_pkg::*;
#(
    parameter int H_ACTIVE   = 160,
    parameter int V_ACTIVE   = 120,
    parameter int H_BLANK    = 4,
    parameter int V_BLANK    = 4,
    parameter int VSYNC_ROWS = 2,
    parameter int PCLK_HALF  = 2,
    parameter int BAR_W      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [11:0] color_a,
    input  logic [11:0] color_b,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int H_TOT = 2 * H_ACTIVE + H_BLANK;
    localparam int V_TOT = V_BLANK + V_ACTIVE;
    localparam int BW    = $clog2(H_TOT + 1);
    localparam int RW    = $clog2(V_TOT + 1);
    localparam int DW    = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;

    localparam logic [BW-1:0] c_byte_last = BW'(H_TOT - 1);
    localparam logic [BW-1:0] c_href_end  = BW'(2 * H_ACTIVE);
    localparam logic [RW-1:0] c_row_last  = RW'(V_TOT - 1);
    localparam logic [RW-1:0] c_vsync_end = RW'(VSYNC_ROWS);
    localparam logic [RW-1:0] c_act_start = RW'(V_BLANK);
    localparam logic [DW-1:0] c_div_last  = DW'(PCLK_HALF - 1);

    logic [DW-1:0] div_q, div_d;
    logic          pclk_q, pclk_d;
    logic          w_div_wrap, w_fall_tick, w_eof, w_active;
    logic [1:0]    state_q, state_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    mode_q, mode_d;
    logic [11:0]   ca_q, ca_d, cb_q, cb_d;
    logic          vsync_q, vsync_d, href_q, href_d, busy_q, busy_d;
    logic [7:0]    data_q, data_d;
    logic [BW-1:0] w_px_x;
    logic [RW-1:0] w_px_y;
    logic [11:0]   w_pat_color;
    logic          w_href_n;

    assign w_div_wrap  = (div_q == c_div_last);
    assign div_d       = w_div_wrap ? '0 : div_q + 1'b1;
    assign pclk_d      = w_div_wrap ? ~pclk_q : pclk_q;
    assign w_fall_tick = w_div_wrap & pclk_q;
    assign w_eof       = (row_q == c_row_last) && (byte_q == c_byte_last);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; every transition waits for a pclk fall tick
    always_comb begin
        state_d = state_q;
        if (w_fall_tick) begin
            case (state_q)
                ST_IDLE:  if (enable) state_d = ST_RUN;
                ST_RUN:   if (!enable) state_d = w_eof ? ST_IDLE : ST_DRAIN;
                ST_DRAIN: begin
                    if (enable)     state_d = ST_RUN;
                    else if (w_eof) state_d = ST_IDLE;
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: position counters and the per-frame pattern latch
    always_comb begin
        byte_d = byte_q;
        row_d  = row_q;
        mode_d = mode_q;
        ca_d   = ca_q;
        cb_d   = cb_q;
        if (w_fall_tick) begin
            if (state_q != ST_IDLE && !w_eof && state_d != ST_IDLE) begin
                if (byte_q == c_byte_last) begin
                    byte_d = '0;
                    row_d  = row_q + 1'b1;
                end else begin
                    byte_d = byte_q + 1'b1;
                end
            end else begin
                byte_d = '0;
                row_d  = '0;
            end
            if (state_d == ST_RUN && (state_q == ST_IDLE || w_eof)) begin
                mode_d = mode;
                ca_d   = color_a;
                cb_d   = color_b;
            end
        end
    end

    assign w_px_x = byte_d >> 1;
    assign w_px_y = row_d - c_act_start;

    cam_gen_pattern #(
        .XW    (BW),
        .YW    (RW),
        .BAR_W (BAR_W)
    ) u_pattern (
        .x_i       (w_px_x),
        .y_i       (w_px_y),
        .mode_i    (mode_d),
        .color_a_i (ca_d),
        .color_b_i (cb_d),
        .color_o   (w_pat_color)
    );

    // Stream outputs describe the position being entered on this fall tick.
    assign w_active = (state_d != ST_IDLE);
    assign w_href_n = w_active && (row_d >= c_act_start) && (byte_d < c_href_end);

    always_comb begin
        vsync_d = vsync_q;
        href_d  = href_q;
        data_d  = data_q;
        busy_d  = busy_q;
        if (w_fall_tick) begin
            vsync_d = w_active && (row_d < c_vsync_end);
            href_d  = w_href_n;
            data_d  = w_href_n ? rgb444_byte(w_pat_color, byte_d[0]) : 8'h00;
            busy_d  = w_active;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            pclk_q  <= 1'b0;
            byte_q  <= '0;
            row_q   <= '0;
            mode_q  <= MODE_SOLID;
            ca_q    <= 12'h000;
            cb_q    <= 12'h000;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            pclk_q  <= pclk_d;
            byte_q  <= byte_d;
            row_q   <= row_d;
            mode_q  <= mode_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

`ifdef CAM_GEN_FRAME_CNT_EN
    logic [15:0] frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 16'h0000;
        end else if (w_fall_tick && state_q != ST_IDLE && w_eof) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    assign frame_cnt = frame_q;
`else
    assign frame_cnt = 16'h0000;
`endif

    assign CAM_pclk    = pclk_q;
    assign CAM_vsync   = vsync_q;
    assign CAM_href    = href_q;
    assign CAM_px_data = data_q;
    assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_stream_gen.sv
// ============================================================================
//  Module      : tb_cam_stream_gen
//  Description : Self-checking bench for cam_stream_gen: two geometries,
//                a frame-position reference model, vector table and sequences.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cam_stream_gen;

    typedef struct packed {
        int ha; int va; int hb; int vb; int vs; int ph; int bw;
    } geo_t;

    localparam geo_t G0 = '{ha: 8, va: 6, hb: 4, vb: 4, vs: 2, ph: 2, bw: 2};
    localparam geo_t G1 = '{ha: 8, va: 4, hb: 2, vb: 3, vs: 1, ph: 1, bw: 2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] color_a = 12'h000;
    logic [11:0] color_b = 12'h000;

    logic        pclk0, vs0, hr0, busy0, pclk1, vs1, hr1, busy1;
    logic [7:0]  d0, d1;
    logic [15:0] fc0, fc1;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    cam_stream_gen #(
        .H_ACTIVE(G0.ha), .V_ACTIVE(G0.va), .H_BLANK(G0.hb), .V_BLANK(G0.vb),
        .VSYNC_ROWS(G0.vs), .PCLK_HALF(G0.ph), .BAR_W(G0.bw)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .color_a(color_a), .color_b(color_b),
        .CAM_pclk(pclk0), .CAM_vsync(vs0), .CAM_href(hr0), .CAM_px_data(d0),
        .busy(busy0), .frame_cnt(fc0)
    );

    cam_stream_gen #(
        .H_ACTIVE(G1.ha), .V_ACTIVE(G1.va), .H_BLANK(G1.hb), .V_BLANK(G1.vb),
        .VSYNC_ROWS(G1.vs), .PCLK_HALF(G1.ph), .BAR_W(G1.bw)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .color_a(color_a), .color_b(color_b),
        .CAM_pclk(pclk1), .CAM_vsync(vs1), .CAM_href(hr1), .CAM_px_data(d1),
        .busy(busy1), .frame_cnt(fc1)
    );

    // Reference model: a frame is a flat sequence of pixel-clock slots.
    int          mk[2];
    bit          mact[2];
    int          mpos[2];
    int          mfr[2];
    logic [1:0]  mmode[2];
    logic [11:0] mca[2];
    logic [11:0] mcb[2];

    function automatic geo_t gsel(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    function automatic logic [7:0] pbyte(input geo_t g, input int row, input int bt,
                                         input logic [1:0] m, input logic [11:0] a,
                                         input logic [11:0] b);
        int x, y, sel;
        logic [11:0] c;
        x = bt / 2;
        y = row - g.vb;
        case (m)
            2'd1:    sel = (x / g.bw) % 2;
            2'd2:    sel = (y / g.bw) % 2;
            2'd3:    sel = ((x / g.bw) + (y / g.bw)) % 2;
            default: sel = 0;
        endcase
        c = (sel != 0) ? b : a;
        return (bt % 2 == 1) ? c[7:0] : {4'h0, c[11:8]};
    endfunction

    function automatic logic [27:0] expv(input int i);
        geo_t g;
        int htot, row, bt;
        logic pc, vs, hr, bz;
        logic [7:0] d;
        logic [15:0] fc;
        g    = gsel(i);
        htot = 2 * g.ha + g.hb;
        pc   = ((mk[i] / g.ph) % 2) == 1;
        vs = 1'b0; hr = 1'b0; d = 8'h00; bz = mact[i];
        if (mact[i]) begin
            row = mpos[i] / htot;
            bt  = mpos[i] % htot;
            vs  = row < g.vs;
            hr  = (row >= g.vb) && (bt < 2 * g.ha);
            if (hr) d = pbyte(g, row, bt, mmode[i], mca[i], mcb[i]);
        end
`ifdef CAM_GEN_FRAME_CNT_EN
        fc = 16'(mfr[i]);
`else
        fc = 16'h0000;
`endif
        return {pc, vs, hr, d, bz, fc};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            geo_t g;
            int ftot;
            g    = gsel(i);
            ftot = (2 * g.ha + g.hb) * (g.vb + g.va);
            if (!rst_n) begin
                mk[i] = 0; mact[i] = 1'b0; mpos[i] = 0; mfr[i] = 0;
            end else begin
                mk[i]++;
                if (mk[i] % (2 * g.ph) == 0) begin
                    if (!mact[i] || mpos[i] == ftot - 1) begin
                        if (mact[i]) mfr[i]++;
                        mpos[i] = 0;
                        mact[i] = enable;
                        if (enable) begin
                            mmode[i] = mode; mca[i] = color_a; mcb[i] = color_b;
                        end
                    end else begin
                        mpos[i]++;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("stream0", 32'({pclk0, vs0, hr0, d0, busy0, fc0}), 32'(expv(0)));
            chk("stream1", 32'({pclk1, vs1, hr1, d1, busy1, fc1}), 32'(expv(1)));
        end
    end

    task automatic wait_pos(input int i, input int target, input int budget);
        int n = 0;
        while (!(mact[i] && mpos[i] == target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(mact[i] && mpos[i] == target)) chk("wait_pos_timeout", 32'(n), 32'(budget + 1));
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        while (mact[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (mact[i]) chk("wait_idle_timeout", 32'(n), 32'(budget + 1));
    endtask

    typedef struct {
        logic [1:0]  m;
        logic [11:0] a;
        logic [11:0] b;
        int          row;
        int          bt;
        logic        vs;
        logic        hr;
        logic [7:0]  d;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int rises, hrun, first_len, n, t0, t1;
        logic prev;

        tbl[0]  = '{2'd0, 12'hF00, 12'h0AB, 4, 0,  1'b0, 1'b1, 8'h0F};
        tbl[1]  = '{2'd0, 12'hF00, 12'h0AB, 4, 1,  1'b0, 1'b1, 8'h00};
        tbl[2]  = '{2'd1, 12'h00F, 12'h0F0, 5, 1,  1'b0, 1'b1, 8'h0F};
        tbl[3]  = '{2'd1, 12'h00F, 12'h0F0, 5, 5,  1'b0, 1'b1, 8'hF0};
        tbl[4]  = '{2'd1, 12'h00F, 12'h0F0, 5, 4,  1'b0, 1'b1, 8'h00};
        tbl[5]  = '{2'd2, 12'h123, 12'h456, 4, 0,  1'b0, 1'b1, 8'h01};
        tbl[6]  = '{2'd2, 12'h123, 12'h456, 6, 1,  1'b0, 1'b1, 8'h56};
        tbl[7]  = '{2'd3, 12'hABC, 12'hDEF, 4, 5,  1'b0, 1'b1, 8'hEF};
        tbl[8]  = '{2'd3, 12'hABC, 12'hDEF, 6, 5,  1'b0, 1'b1, 8'hBC};
        tbl[9]  = '{2'd3, 12'hABC, 12'hDEF, 6, 0,  1'b0, 1'b1, 8'h0D};
        tbl[10] = '{2'd0, 12'hF00, 12'h0AB, 4, 16, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{2'd0, 12'hF00, 12'h0AB, 1, 0,  1'b1, 1'b0, 8'h00};

        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        chk("reset_state", 32'({pclk0, vs0, hr0, d0, busy0, fc0}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 12; r++) begin
            wait_idle(0, 2000);
            mode = tbl[r].m; color_a = tbl[r].a; color_b = tbl[r].b;
            enable = 1'b1;
            wait_pos(0, tbl[r].row * 20 + tbl[r].bt, 2000);
            chk($sformatf("vec%0d", r), 32'({vs0, hr0, d0}), 32'({tbl[r].vs, tbl[r].hr, tbl[r].d}));
            enable = 1'b0;
        end
        wait_idle(0, 2000);

        // Three full frames from a fresh reset: href pulses, width, frame count
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mode = 2'd0; color_a = 12'hF00; color_b = 12'h000;
        enable = 1'b1;
        rises = 0; hrun = 0; first_len = 0; n = 0; prev = 1'b0;
        while (mfr[0] < 3 && n < 4000) begin
            @(negedge clk);
            n++;
            if (hr0 && !prev) rises++;
            if (hr0) hrun++;
            else if (prev && first_len == 0) first_len = hrun;
            if (!hr0) hrun = 0;
            prev = hr0;
        end
        chk("href_pulses", 32'(rises), 32'(3 * G0.va));
        chk("href_width_clk", 32'(first_len), 32'(2 * G0.ha * 2 * G0.ph));
`ifdef CAM_GEN_FRAME_CNT_EN
        chk("frame_cnt_3", 32'(fc0), 32'd3);
`else
        chk("frame_cnt_3", 32'(fc0), 32'd0);
`endif

        // Asynchronous reset in the middle of an active line
        wait_pos(0, 5 * 20 + 3, 1000);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 32'({pclk0, vs0, hr0, d0, busy0, fc0}), 32'h0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_after_reset", 32'({vs0, hr0, busy0, fc0}), 32'h0);

        // Enable dropped mid-frame: frame drains, busy falls, no new vsync
        enable = 1'b1;
        wait_pos(0, 5 * 20, 1000);
        enable = 1'b0;
        n = 0;
        while (busy0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy_low", 32'(busy0), 32'd0);
        chk("drain_length_clk", 32'(n / (2 * G0.ph)), 32'(200 - 100));
        rises = 0; prev = vs0;
        repeat (900) begin
            @(negedge clk);
            if (vs0 && !prev) rises++;
            prev = vs0;
        end
        chk("no_vsync_after_drain", 32'(rises), 32'd0);

        // Mode change mid-frame only takes effect on the next frame
        mode = 2'd0; color_a = 12'hF00; color_b = 12'h00F;
        enable = 1'b1;
        wait_pos(0, 6 * 20, 1000);
        mode = 2'd2;
        wait_pos(0, 7 * 20, 1000);
        chk("mode_hold_cur_frame", 32'(d0), 32'h0F);
        wait_pos(0, 6 * 20, 1000);
        chk("mode_next_frame", 32'(d0), 32'h00);

        // Second instance pixel clock period is 2 clk
        n = 0; t0 = -1; t1 = -1; prev = pclk1;
        while (t1 < 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (pclk1 && !prev) begin
                if (t0 < 0) t0 = n; else t1 = n;
            end
            prev = pclk1;
        end
        chk("pclk1_period", 32'(t1 - t0), 32'd2);

        // Randomised mode/colour/enable activity checked by the stream monitor
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            mode    = 2'($urandom_range(0, 3));
            color_a = 12'($urandom);
            color_b = 12'($urandom);
            enable  = ($urandom_range(0, 9) < 7);
            repeat ($urandom_range(20, 900)) @(negedge clk);
        end

        enable = 1'b0;
        wait_idle(0, 2000);
        wait_idle(1, 2000);
        repeat (4) @(negedge clk);
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
